sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Downstream drain stage for the systolic array core. Waits until every column output controller reports a valid result, then captures the full ROWS-wide result vector into a small vector FIFO and returns a one-cycle `outread` pulse to the core. It serializes buffered vectors one column at a time onto a single valid/ready stream, with optional ReLU clamping, for the writeback path.

## Interface
Parameters:
- `ROWS`, 8: columns per result vector; must match the core.
- `OUTWIDTH`, 32: result word width; words are treated as two's-complement signed.
- `DEPTH`, 2: vector FIFO depth in whole vectors; must be at least 1.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous active-low reset.
- `rinport`  in  `OUTWIDTH` x [0:ROWS-1]  per-column results from the core's `routport`.
- `rvalidport`  in  [0:ROWS-1]  per-column valid flags from the core.
- `outread`  out  1  one-cycle pulse: the current result vector has been consumed.
- `relu_en`  in  1  when 1, negative words are emitted as 0.
- `m_data`  out  `OUTWIDTH`  serialized result word.
- `m_col`  out  `$clog2(ROWS)`  column index of `m_data`; minimum width 1.
- `m_last`  out  1  high on column ROWS-1 of each vector.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `vcount`  out  `$clog2(DEPTH+1)`  number of vectors held, including the one currently draining.

## Operation
- The reset value of every output and every register is 0. `outread`, `m_valid`, `m_last`, `m_col`, `m_data` and `vcount` are all 0.
- Capture condition, evaluated each cycle: `&rvalidport && vcount < DEPTH && !holdoff`.
  - On capture, all ROWS words are written into FIFO slot `wr_ptr` at the clock edge.
  - On capture, `wr_ptr` advances modulo DEPTH.
  - On capture, registered `outread` and `holdoff` are set for exactly the following cycle.
- `holdoff` blocks a second capture during the `outread` cycle, while the core is still withdrawing its valids.
- Partial valids (some bits of `rvalidport` low) cause no action. The block waits and never captures a partial vector.
- When the FIFO is full, capture stalls. `outread` stays low, so the core holds its outputs.
- "Full" uses the registered `vcount`. A pop in the same cycle does not permit a push while full, so the push occurs one cycle later.
- The serializer has two states:
  - IDLE: `m_valid`=0. Move to SEND when `vcount`>0.
  - SEND: `m_valid`=1. `m_data` = word `col` of slot `rd_ptr`, after ReLU. `m_col`=`col`. `m_last`=(`col`==ROWS-1).
  - On a handshake (`m_valid && m_ready`) with `col`<ROWS-1, `col` increments.
  - On a handshake with `col`==ROWS-1: `col` returns to 0, `rd_ptr` advances modulo DEPTH, and `vcount` decrements.
  - After that final handshake, the serializer stays in SEND if another vector remains (post-pop `vcount`>0). Otherwise it returns to IDLE.
- When a push and a pop happen in the same cycle, `vcount` is unchanged and both pointers advance.
- `m_data`, `m_col` and `m_last` must stay stable while `m_valid && !m_ready`.
- ReLU:
  - With `relu_en`=1, if bit OUTWIDTH-1 of the word is 1, `m_data`=0. Otherwise the word passes unchanged.
  - With `relu_en`=0, the word always passes unchanged.
  - `relu_en` is sampled combinationally at output time, not at capture.
  - No width change and no saturation.
- Reset asserted mid-operation (rstn low at any time) immediately clears the FIFO, pointers, `col`, state and `holdoff`, and all outputs go to 0. Any partially emitted vector is discarded, with no `m_last` sent for it.

## Timing
- A capture at edge N gives `outread`=1 during cycle N+1 and 0 in cycle N+2, unless another capture occurs at edge N+2.
- Capture-to-stream latency: if the FIFO was empty, `m_valid`=1 in cycle N+1 with `m_col`=0.
- Throughput with `m_ready` held high: one word per cycle, ROWS cycles per vector, and no bubble between consecutive vectors.
- Minimum spacing between captures is 2 cycles, set by the holdoff.
- Backpressure is `m_ready`=0 for any number of cycles. No word is lost or duplicated.
- `vcount` updates at the clock edge of the push or pop.

## Test plan
- **Reset:** with `rstn` low, drive all `rvalidport` high → `outread`=0, `m_valid`=0, `vcount`=0. After release, capture occurs on the first edge.
- **Single vector, ROWS=8, `m_ready` high:** drive `rinport` = 1..8 with all valids set for 1 cycle →
  - one `outread` pulse the cycle after capture;
  - `m_data` sequence 1..8 with `m_col` 0..7;
  - `m_last` only on value 8;
  - `vcount` then returns to 0.
- **Partial valid:** `rvalidport`=8'b1111_1110 held for 10 cycles → no `outread` and `vcount`=0. Setting the last bit then triggers capture on the next edge.
- **FIFO full, DEPTH=2, `m_ready` low:**
  - present 3 vectors → `vcount`=2, third vector not captured, `outread` pulsed exactly twice;
  - raise `m_ready` → after the 8th handshake, the third vector is captured one cycle later;
  - all 24 words emerge in order.
- **ReLU and backpressure:** `rinport` = {-5, 7, 0x8000_0000, 3, ...}, `relu_en`=1, with `m_ready` toggled 1010 →
  - emitted words are 0, 7, 0, 3, ...;
  - outputs are stable during stalls;
  - with `relu_en`=0, -5 appears as 0xFFFF_FFFB.
- **Mid-stream reset:** pulse `rstn` low asynchronously while `m_col`=3 → outputs go to 0 immediately and `vcount`=0. After release, no stale words are emitted and a new vector streams from `m_col`=0.

Source files
------------

// File: rtl/sa_result_drain_if.sv
// Serialized result stream carrying one column of one result vector per beat.
interface sa_result_drain_if #(
    parameter int OUTWIDTH = 32,
    parameter int COLW     = 3
);
    logic [OUTWIDTH-1:0] m_data;
    logic [COLW-1:0]     m_col;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;

    modport master (
        output m_data,
        output m_col,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_col,
        input  m_last,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/sa_result_drain.sv
// Drain stage for the systolic array core: captures complete result vectors
// into a small vector FIFO, acknowledges each capture with a one-cycle
// outread pulse, and serializes buffered vectors one column per beat with
// optional ReLU clamping.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no buffered vector, stream output idle
// SEND  | presenting word col_q of slot rd_ptr_q on the stream
module sa_result_drain #(
    parameter  int ROWS     = 8,
    parameter  int OUTWIDTH = 32,
    parameter  int DEPTH    = 2,
    localparam int COLW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [OUTWIDTH-1:0] rinport [0:ROWS-1],
    input  logic [0:ROWS-1]     rvalidport,
    output logic                outread,
    input  logic                relu_en,
    output logic [CNTW-1:0]     vcount,
    sa_result_drain_if.master   m
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [COLW-1:0] COL_LAST = COLW'(ROWS - 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [OUTWIDTH-1:0] mem_q [0:DEPTH-1][0:ROWS-1];

    logic [0:0]          state_q,  state_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [COLW-1:0]     col_q,    col_d;
    logic [CNTW-1:0]     vcount_q, vcount_d;
    logic                outread_q;
    logic                holdoff_q;

    logic                push;
    logic                pop;
    logic                sending;
    logic                beat;
    logic [OUTWIDTH-1:0] rd_word;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTRW'(1);
    endfunction

    // Capture/pop decisions and next-state for pointers, column and occupancy.
    // Fullness is judged on the registered count only, so a pop never frees
    // a slot for a push in the same cycle.
    always_comb begin
        sending  = (state_q == ST_SEND);
        beat     = sending && m.m_ready;
        push     = (&rvalidport) && (vcount_q < CNT_FULL) && !holdoff_q;
        pop      = beat && (col_q == COL_LAST);

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        col_d = col_q;
        if (beat) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + COLW'(1);
        end

        vcount_d = vcount_q;
        if (push && !pop) begin
            vcount_d = vcount_q + CNTW'(1);
        end else if (pop && !push) begin
            vcount_d = vcount_q - CNTW'(1);
        end

        // Looking at the post-update count lets a capture into an empty FIFO
        // start streaming in the very next cycle, and lets back-to-back
        // vectors stream without a bubble.
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (vcount_d != '0) ? ST_SEND : ST_IDLE;
            ST_SEND: state_d = (vcount_d != '0) ? ST_SEND : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; outread and holdoff both mark the cycle after a capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            col_q     <= '0;
            vcount_q  <= '0;
            outread_q <= 1'b0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            col_q     <= col_d;
            vcount_q  <= vcount_d;
            outread_q <= push;
            holdoff_q <= push;
        end
    end

    // Vector storage; a whole ROWS-wide vector lands in one slot per capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int c = 0; c < ROWS; c++) begin
                    mem_q[s][c] <= '0;
                end
            end
        end else if (push) begin
            for (int c = 0; c < ROWS; c++) begin
                mem_q[wr_ptr_q][c] <= rinport[c];
            end
        end
    end

    // Stream outputs; the read slot is never the write slot while sending,
    // so the presented word holds steady under backpressure.
    always_comb begin
        rd_word   = mem_q[rd_ptr_q][col_q];
        m.m_valid = sending;
        m.m_col   = col_q;
        m.m_last  = sending && (col_q == COL_LAST);
        m.m_data  = '0;
        if (sending && !(relu_en && rd_word[OUTWIDTH-1])) begin
            m.m_data = rd_word;
        end
    end

    assign outread = outread_q;
    assign vcount  = vcount_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain with a word-level scoreboard.
module tb_sa_result_drain;

    localparam int ROWS     = 8;
    localparam int OUTWIDTH = 32;
    localparam int DEPTH    = 2;
    localparam int COLW     = 3;
    localparam int CNTW     = 2;

    typedef struct packed {
        logic [OUTWIDTH-1:0] data;
        logic [COLW-1:0]     col;
    } exp_t;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [OUTWIDTH-1:0] rin [0:ROWS-1];
    logic [0:ROWS-1]     rvalid = '0;
    logic                outread;
    logic                relu_en = 1'b0;
    logic [CNTW-1:0]     vcount;

    sa_result_drain_if #(.OUTWIDTH(OUTWIDTH), .COLW(COLW)) m_if ();

    sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(OUTWIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rinport    (rin),
        .rvalidport (rvalid),
        .outread    (outread),
        .relu_en    (relu_en),
        .vcount     (vcount),
        .m          (m_if)
    );

    always #5 clk = ~clk;

    int   n_err    = 0;
    int   n_checks = 0;
    int   pulses   = 0;
    exp_t sb[$];

    logic        prev_stall = 1'b0;
    logic [35:0] prev_out   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input int base);
        for (int i = 0; i < ROWS; i++) rin[i] = OUTWIDTH'(base + i + 1);
    endtask

    task automatic push_vec();
        exp_t e;
        for (int i = 0; i < ROWS; i++) begin
            e.data = rin[i];
            e.col  = COLW'(i);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (!(sb.size() == 0 && vcount == '0 && !m_if.m_valid) && k < 200) begin
            tick();
            k++;
        end
        check(tag, (sb.size() == 0 && vcount == '0 && !m_if.m_valid), 1);
    endtask

    // Stream monitor: stability under stall, then scoreboard compare on handshake.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (outread) pulses++;
            if (prev_stall) begin
                check("stall_valid", m_if.m_valid, 1);
                check("stall_stable", {m_if.m_data, m_if.m_col, m_if.m_last}, prev_out);
            end
            if (m_if.m_valid && m_if.m_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    w = (relu_en && e.data[OUTWIDTH-1]) ? '0 : e.data;
                    check("stream_data", m_if.m_data, w);
                    check("stream_col", m_if.m_col, e.col);
                    check("stream_last", m_if.m_last, e.col == COLW'(ROWS - 1));
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_out   = {m_if.m_data, m_if.m_col, m_if.m_last};
        end
    end

    initial begin
        int p0;
        int k;
        m_if.m_ready = 1'b1;
        load_seq(0);

        // Reset holds everything idle even with all valids high.
        rvalid = '1;
        tick();
        tick();
        check("rst_outread", outread, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_vcount", vcount, 0);
        check("rst_data", m_if.m_data, 0);

        // Release: capture on the first edge, single vector 1..8.
        rstn = 1'b1;
        push_vec();
        tick();
        check("cap_outread", outread, 1);
        check("cap_vcount", vcount, 1);
        check("cap_valid", m_if.m_valid, 1);
        check("cap_col", m_if.m_col, 0);
        check("cap_data", m_if.m_data, 1);
        rvalid = '0;
        tick();
        check("outread_end", outread, 0);
        wait_drain("drain_single");
        check("single_pulses", pulses, 1);

        // Partial valids never capture.
        load_seq(10);
        rvalid = 8'b1111_1110;
        p0 = pulses;
        for (int i = 0; i < 10; i++) tick();
        check("partial_pulses", pulses, p0);
        check("partial_vcount", vcount, 0);
        rvalid = '1;
        push_vec();
        tick();
        check("partial_cap", outread, 1);
        rvalid = '0;
        wait_drain("drain_partial");

        // FIFO full with backpressure, then release.
        m_if.m_ready = 1'b0;
        p0 = pulses;
        load_seq(20); push_vec(); rvalid = '1;
        tick(); rvalid = '0; tick();
        load_seq(30); push_vec(); rvalid = '1;
        tick(); rvalid = '0; tick();
        load_seq(40); push_vec(); rvalid = '1;
        for (int i = 0; i < 4; i++) tick();
        check("full_vcount", vcount, 2);
        check("full_outread", outread, 0);
        check("full_pulses", pulses - p0, 2);
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("full_pop_vcount", vcount, 1);
        check("full_pop_nocap", outread, 0);
        tick();
        check("full_late_cap", outread, 1);
        check("full_late_vcount", vcount, 2);
        rvalid = '0;
        wait_drain("drain_full");

        // ReLU with alternating backpressure.
        relu_en = 1'b1;
        m_if.m_ready = 1'b0;
        rin[0] = 32'hFFFF_FFFB; rin[1] = 32'd7;  rin[2] = 32'h8000_0000; rin[3] = 32'd3;
        rin[4] = 32'hFFFF_FFFF; rin[5] = 32'd100; rin[6] = 32'h7FFF_FFFF; rin[7] = 32'hFFFF_FF9C;
        push_vec();
        rvalid = '1;
        tick();
        rvalid = '0;
        check("relu_first", m_if.m_data, 0);
        check("relu_first_col", m_if.m_col, 0);
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            m_if.m_ready = (k % 2 == 0);
            tick();
            k++;
        end
        m_if.m_ready = 1'b1;
        wait_drain("drain_relu");

        // Same negative word passes unchanged with ReLU off.
        relu_en = 1'b0;
        m_if.m_ready = 1'b0;
        push_vec();
        rvalid = '1;
        tick();
        rvalid = '0;
        check("norelu_first", m_if.m_data, 32'hFFFF_FFFB);
        tick();
        tick();
        m_if.m_ready = 1'b1;
        wait_drain("drain_norelu");

        // Mid-stream asynchronous reset.
        load_seq(40);
        push_vec();
        rvalid = '1;
        tick();
        rvalid = '0;
        k = 0;
        while (!(m_if.m_valid && m_if.m_col == 3) && k < 20) begin
            tick();
            k++;
        end
        check("mid_reach_col3", m_if.m_col, 3);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", m_if.m_valid, 0);
        check("mid_rst_data", m_if.m_data, 0);
        check("mid_rst_col", m_if.m_col, 0);
        check("mid_rst_last", m_if.m_last, 0);
        check("mid_rst_vcount", vcount, 0);
        sb.delete();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_idle", m_if.m_valid, 0);
        load_seq(50);
        push_vec();
        rvalid = '1;
        tick();
        rvalid = '0;
        check("post_rst_col", m_if.m_col, 0);
        check("post_rst_data", m_if.m_data, 51);
        wait_drain("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
